// File: rtl/music_box_core_if.sv
// Bus between the keypad/PS2 decode logic and the music box core.
// The master drives buttons, note step and keyboard note; the slave returns tone and sequencer state.
interface music_box_core_if;
  logic        song1;
  logic        song2;
  logic        song3;
  logic        song4;
  logic        stop_song;
  logic        note_step;
  logic        music_box;
  logic [19:0] key_note;
  logic        play_enable;
  logic        kclk;
  logic [19:0] note;
  logic [1:0]  duration;
  logic        playing;
  logic        speaker;

  modport master (
    output song1, song2, song3, song4, stop_song, note_step,
    output music_box, key_note, play_enable,
    input  kclk, note, duration, playing, speaker
  );

  modport slave (
    input  song1, song2, song3, song4, stop_song, note_step,
    input  music_box, key_note, play_enable,
    output kclk, note, duration, playing, speaker
  );
endinterface

// File: rtl/music_box_core.sv
// Music box core: PS/2 clock divider, four-song note sequencer and square-wave tone generator.
// Note values are half-periods in 100 MHz clock cycles, so the speaker period is twice the count.
module music_box_core (
  input  logic             clk,
  input  logic             rst,
  music_box_core_if.slave  bus
);

  localparam logic [19:0] C4 = 20'd191109;
  localparam logic [19:0] D4 = 20'd170265;
  localparam logic [19:0] E4 = 20'd151685;
  localparam logic [19:0] F4 = 20'd143172;
  localparam logic [19:0] G4 = 20'd127550;
  localparam logic [19:0] A4 = 20'd113636;
  localparam logic [19:0] B4 = 20'd101238;
  localparam logic [19:0] C5 = 20'd95556;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  // Each entry packs {note, duration}; unused slots read as silence.
  function automatic logic [21:0] romEntry(input logic [1:0] song, input logic [3:0] idx);
    logic [21:0] e;
    e = '0;
    case (song)
      2'd0: begin
        case (idx)
          4'd0: e = {C4, 2'd1};
          4'd1: e = {D4, 2'd1};
          4'd2: e = {E4, 2'd1};
          4'd3: e = {F4, 2'd1};
          4'd4: e = {G4, 2'd1};
          4'd5: e = {A4, 2'd1};
          4'd6: e = {B4, 2'd1};
          4'd7: e = {C5, 2'd1};
          default: e = '0;
        endcase
      end
      2'd1: begin
        case (idx)
          4'd0: e = {C5, 2'd1};
          4'd1: e = {B4, 2'd1};
          4'd2: e = {A4, 2'd1};
          4'd3: e = {G4, 2'd1};
          4'd4: e = {F4, 2'd1};
          4'd5: e = {E4, 2'd1};
          4'd6: e = {D4, 2'd1};
          4'd7: e = {C4, 2'd1};
          default: e = '0;
        endcase
      end
      2'd2: begin
        case (idx)
          4'd0: e = {C4, 2'd0};
          4'd1: e = {E4, 2'd0};
          4'd2: e = {G4, 2'd0};
          4'd3: e = {C5, 2'd2};
          4'd4: e = {C4, 2'd0};
          4'd5: e = {E4, 2'd0};
          4'd6: e = {G4, 2'd0};
          4'd7: e = {C5, 2'd2};
          default: e = '0;
        endcase
      end
      default: begin
        case (idx)
          4'd0: e = {A4, 2'd1};
          4'd1: e = {A4, 2'd1};
          4'd2: e = {G4, 2'd1};
          4'd3: e = {E4, 2'd1};
          4'd4: e = {C4, 2'd3};
          default: e = '0;
        endcase
      end
    endcase
    return e;
  endfunction

  function automatic logic [4:0] songLen(input logic [1:0] song);
    return (song == 2'd3) ? 5'd5 : 5'd8;
  endfunction

  state_t      r_state;
  logic [1:0]  r_song;
  logic [3:0]  r_idx;
  logic [19:0] r_note;
  logic [1:0]  r_dur;
  logic        r_playing;
  logic [3:0]  r_btnHist;
  logic        r_kclk;
  logic [19:0] r_cnt;
  logic        r_speaker;

  logic [3:0]  w_btn;
  logic [3:0]  w_press;
  logic [1:0]  w_pressSong;
  logic [3:0]  w_nextIdx;
  logic        w_lastNote;
  logic [21:0] w_pressEntry;
  logic [21:0] w_stepEntry;
  logic [19:0] w_tc;

  assign w_btn        = {bus.song4, bus.song3, bus.song2, bus.song1};
  assign w_press      = w_btn & ~r_btnHist;
  assign w_nextIdx    = r_idx + 4'd1;
  assign w_lastNote   = (({1'b0, r_idx} + 5'd1) == songLen(r_song));
  assign w_pressEntry = romEntry(w_pressSong, 4'd0);
  assign w_stepEntry  = romEntry(r_song, w_nextIdx);

  // Lowest-numbered button wins when several are pressed together.
  always_comb begin
    w_pressSong = 2'd0;
    if (w_press[0])      w_pressSong = 2'd0;
    else if (w_press[1]) w_pressSong = 2'd1;
    else if (w_press[2]) w_pressSong = 2'd2;
    else if (w_press[3]) w_pressSong = 2'd3;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_kclk <= 1'b0;
    end else begin
      r_kclk <= ~r_kclk;
    end
  end

  // Outputs are loaded from the ROM on the same edge that changes state, so they never lag a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_song    <= 2'd0;
      r_idx     <= 4'd0;
      r_note    <= 20'd0;
      r_dur     <= 2'd0;
      r_playing <= 1'b0;
      r_btnHist <= 4'd0;
    end else begin
      r_btnHist <= w_btn;
      if (bus.stop_song) begin
        r_state   <= IDLE;
        r_idx     <= 4'd0;
        r_note    <= 20'd0;
        r_dur     <= 2'd0;
        r_playing <= 1'b0;
      end else if (|w_press) begin
        r_state   <= PLAY;
        r_song    <= w_pressSong;
        r_idx     <= 4'd0;
        r_note    <= w_pressEntry[21:2];
        r_dur     <= w_pressEntry[1:0];
        r_playing <= 1'b1;
      end else if (r_state == PLAY && bus.note_step) begin
        if (w_lastNote) begin
          r_state   <= IDLE;
          r_idx     <= 4'd0;
          r_note    <= 20'd0;
          r_dur     <= 2'd0;
          r_playing <= 1'b0;
        end else begin
          r_idx     <= w_nextIdx;
          r_note    <= w_stepEntry[21:2];
          r_dur     <= w_stepEntry[1:0];
        end
      end
    end
  end

  assign w_tc = bus.play_enable ? (bus.music_box ? r_note : bus.key_note) : 20'd0;

  // The >= compare lets a shortened count take effect at once instead of wrapping the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= 20'd0;
      r_speaker <= 1'b0;
    end else if (w_tc == 20'd0) begin
      r_cnt     <= 20'd0;
      r_speaker <= 1'b0;
    end else if (r_cnt >= (w_tc - 20'd1)) begin
      r_cnt     <= 20'd0;
      r_speaker <= ~r_speaker;
    end else begin
      r_cnt     <= r_cnt + 20'd1;
    end
  end

  assign bus.kclk     = r_kclk;
  assign bus.note     = r_note;
  assign bus.duration = r_dur;
  assign bus.playing  = r_playing;
  assign bus.speaker  = r_speaker;

endmodule

// File: tb/tb_music_box_core.sv
// Directed bench for music_box_core: table of sequencer vectors plus hand sequences for
// clock divider, tone timing, reset mid-song and held buttons.
module tb_music_box_core;

  logic clk;
  logic rst;
  int   nCompared;
  int   nMismatched;

  music_box_core_if bus();

  music_box_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  btn;
    logic        stop;
    logic        step;
    logic [19:0] expNote;
    logic [1:0]  expDur;
    logic        expPlay;
    int          gap;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] btn, input logic stop, input logic step,
                              input logic [19:0] n, input logic [1:0] d, input logic p,
                              input int gap);
    vec_t v;
    v.btn = btn; v.stop = stop; v.step = step;
    v.expNote = n; v.expDur = d; v.expPlay = p; v.gap = gap;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] btn, input logic stop, input logic step);
    bus.song1     = btn[0];
    bus.song2     = btn[1];
    bus.song3     = btn[2];
    bus.song4     = btn[3];
    bus.stop_song = stop;
    bus.note_step = step;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkSeq(input string tag, input logic [19:0] n, input logic [1:0] d, input logic p);
    checkOutput({tag, ".note"}, 32'(bus.note), 32'(n));
    checkOutput({tag, ".duration"}, 32'(bus.duration), 32'(d));
    checkOutput({tag, ".playing"}, 32'(bus.playing), 32'(p));
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;

    // Sequencer vectors: {buttons, stop, step} -> {note, duration, playing}, then idle gap.
    vecs.push_back(mk(4'b0001, 0, 0, 20'd191109, 2'd1, 1, 20));
    vecs.push_back(mk(4'b0000, 0, 1, 20'd170265, 2'd1, 1, 20));
    vecs.push_back(mk(4'b0000, 0, 1, 20'd151685, 2'd1, 1, 20));
    vecs.push_back(mk(4'b0000, 0, 1, 20'd143172, 2'd1, 1, 20));
    vecs.push_back(mk(4'b0000, 0, 1, 20'd127550, 2'd1, 1, 20));
    vecs.push_back(mk(4'b0000, 0, 1, 20'd113636, 2'd1, 1, 20));
    vecs.push_back(mk(4'b0000, 0, 1, 20'd101238, 2'd1, 1, 20));
    vecs.push_back(mk(4'b0000, 0, 1, 20'd95556,  2'd1, 1, 20));
    vecs.push_back(mk(4'b0000, 0, 1, 20'd0,      2'd0, 0, 3));
    vecs.push_back(mk(4'b0000, 0, 1, 20'd0,      2'd0, 0, 3));
    vecs.push_back(mk(4'b1000, 0, 0, 20'd113636, 2'd1, 1, 3));
    vecs.push_back(mk(4'b0000, 0, 1, 20'd113636, 2'd1, 1, 3));
    vecs.push_back(mk(4'b0000, 0, 1, 20'd127550, 2'd1, 1, 3));
    vecs.push_back(mk(4'b0000, 1, 0, 20'd0,      2'd0, 0, 3));
    vecs.push_back(mk(4'b0101, 0, 0, 20'd191109, 2'd1, 1, 3));
    vecs.push_back(mk(4'b0000, 0, 1, 20'd170265, 2'd1, 1, 3));
    vecs.push_back(mk(4'b0000, 0, 1, 20'd151685, 2'd1, 1, 3));
    vecs.push_back(mk(4'b0010, 0, 0, 20'd95556,  2'd1, 1, 3));
    vecs.push_back(mk(4'b0000, 0, 1, 20'd101238, 2'd1, 1, 3));
    vecs.push_back(mk(4'b0100, 0, 1, 20'd191109, 2'd0, 1, 3));
    vecs.push_back(mk(4'b0000, 0, 1, 20'd151685, 2'd0, 1, 3));
    vecs.push_back(mk(4'b0000, 0, 1, 20'd127550, 2'd0, 1, 3));
    vecs.push_back(mk(4'b0000, 0, 1, 20'd95556,  2'd2, 1, 3));
    vecs.push_back(mk(4'b0000, 0, 1, 20'd191109, 2'd0, 1, 3));
    vecs.push_back(mk(4'b0010, 1, 0, 20'd0,      2'd0, 0, 3));
    vecs.push_back(mk(4'b1000, 0, 0, 20'd113636, 2'd1, 1, 3));
    vecs.push_back(mk(4'b0000, 0, 1, 20'd113636, 2'd1, 1, 3));
    vecs.push_back(mk(4'b0000, 0, 1, 20'd127550, 2'd1, 1, 3));
    vecs.push_back(mk(4'b0000, 0, 1, 20'd151685, 2'd1, 1, 3));
    vecs.push_back(mk(4'b0000, 0, 1, 20'd191109, 2'd3, 1, 3));
    vecs.push_back(mk(4'b0000, 0, 1, 20'd0,      2'd0, 0, 3));

    applyStimulus(4'b0000, 1'b0, 1'b0);
    bus.music_box   = 1'b1;
    bus.play_enable = 1'b0;
    bus.key_note    = 20'd0;
    rst = 1'b1;
    repeat (3) tick();
    checkOutput("reset.kclk", 32'(bus.kclk), 32'd0);
    checkOutput("reset.speaker", 32'(bus.speaker), 32'd0);
    checkSeq("reset", 20'd0, 2'd0, 1'b0);

    // Divider: first edge after release drives kclk high.
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput($sformatf("kclk[%0d]", i), 32'(bus.kclk), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    checkOutput("idle.speaker", 32'(bus.speaker), 32'd0);
    checkSeq("idle", 20'd0, 2'd0, 1'b0);

    $display("[TB] tone from key_note");
    bus.music_box   = 1'b0;
    bus.play_enable = 1'b1;
    bus.key_note    = 20'd4;
    for (int n = 1; n <= 14; n++) begin
      tick();
      checkOutput($sformatf("tone4[%0d]", n), 32'(bus.speaker), 32'((n / 4) % 2));
    end
    bus.key_note = 20'd0;
    tick();
    checkOutput("tone.silence", 32'(bus.speaker), 32'd0);

    // Count shrinks from 10 to 3 with the counter already at 7: toggle on the next edge.
    bus.key_note = 20'd10;
    repeat (7) tick();
    checkOutput("tone10.pre", 32'(bus.speaker), 32'd0);
    bus.key_note = 20'd3;
    tick();
    checkOutput("tone.shrink", 32'(bus.speaker), 32'd1);
    repeat (2) tick();
    checkOutput("tone3.hold", 32'(bus.speaker), 32'd1);
    tick();
    checkOutput("tone3.toggle", 32'(bus.speaker), 32'd0);
    repeat (2) tick();
    bus.play_enable = 1'b0;
    tick();
    checkOutput("tone.disable", 32'(bus.speaker), 32'd0);
    bus.key_note  = 20'd0;
    bus.music_box = 1'b1;

    $display("[TB] sequencer vectors");
    for (int v = 0; v < vecs.size(); v++) begin
      applyStimulus(vecs[v].btn, vecs[v].stop, vecs[v].step);
      tick();
      checkSeq($sformatf("vec%0d", v), vecs[v].expNote, vecs[v].expDur, vecs[v].expPlay);
      applyStimulus(4'b0000, 1'b0, 1'b0);
      repeat (vecs[v].gap) tick();
      checkOutput($sformatf("vec%0d.holdNote", v), 32'(bus.note), 32'(vecs[v].expNote));
      checkOutput($sformatf("vec%0d.holdPlay", v), 32'(bus.playing), 32'(vecs[v].expPlay));
    end

    $display("[TB] reset mid-song");
    applyStimulus(4'b0001, 1'b0, 1'b0);
    tick();
    applyStimulus(4'b0000, 1'b0, 1'b1);
    tick();
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("midsong.note", 32'(bus.note), 32'd170265);
    bus.music_box   = 1'b0;
    bus.play_enable = 1'b1;
    bus.key_note    = 20'd3;
    repeat (5) tick();
    checkOutput("midsong.speaker", 32'(bus.speaker), 32'd1);
    bus.music_box = 1'b1;
    rst = 1'b1;
    tick();
    checkOutput("rstmid.kclk", 32'(bus.kclk), 32'd0);
    checkOutput("rstmid.speaker", 32'(bus.speaker), 32'd0);
    checkSeq("rstmid", 20'd0, 2'd0, 1'b0);
    rst = 1'b0;
    bus.music_box = 1'b0;
    repeat (2) tick();
    checkOutput("rstmid.cntCleared", 32'(bus.speaker), 32'd0);
    checkOutput("rstmid.stayIdle", 32'(bus.playing), 32'd0);
    tick();
    checkOutput("rstmid.firstToggle", 32'(bus.speaker), 32'd1);
    bus.play_enable = 1'b0;
    bus.key_note    = 20'd0;
    bus.music_box   = 1'b1;

    $display("[TB] held button");
    applyStimulus(4'b0010, 1'b0, 1'b0);
    tick();
    checkSeq("held.press", 20'd95556, 2'd1, 1'b1);
    applyStimulus(4'b0010, 1'b0, 1'b1);
    tick();
    checkOutput("held.step", 32'(bus.note), 32'd101238);
    applyStimulus(4'b0010, 1'b0, 1'b0);
    repeat (5) tick();
    checkOutput("held.noRestart", 32'(bus.note), 32'd101238);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    tick();
    applyStimulus(4'b0010, 1'b0, 1'b0);
    tick();
    checkOutput("held.repress", 32'(bus.note), 32'd95556);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
